imm_materializer: RTL and testbench

IMM_MATERIALIZER -- requirements
Module: imm_materializer

---
 rtl/imm_materializer.sv | 105 ++++++++++
 tb/tb_imm_materializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_materializer.sv
// Turns a 64-bit constant into a MOVZ/MOVK instruction sequence, one IW-type
// word per beat, skipping zero halfwords. Two states: IDLE accepts, EMIT drains.
module imm_materializer #(
  parameter logic [8:0] MOVZ_OPC = 9'h1A5,
  parameter logic [8:0] MOVK_OPC = 9'h1E5
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and out_instr/out_last hold while
  // out_valid=1 and out_ready=0.
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state, state_next;
  logic [63:0] value_q;
  logic [4:0]  rd_q;
  logic [3:0]  mask_q;
  logic        first_q;

  logic        accept, complete;
  logic [3:0]  sel_bit, rest_mask;
  logic [1:0]  hw;
  logic [15:0] imm;
  logic        last_beat;

  assign accept   = in_valid && in_ready;
  assign complete = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)               state_next = EMIT;
      EMIT:    if (out_ready && last_beat) state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
    busy      = (state == EMIT);
  end

  // Lowest pending halfword; an empty mask falls back to hw=0 for the zero case.
  always_comb begin
    sel_bit   = mask_q & (~mask_q + 4'd1);
    rest_mask = mask_q & ~sel_bit;
    last_beat = (rest_mask == 4'd0);
    if (mask_q[0])      hw = 2'd0;
    else if (mask_q[1]) hw = 2'd1;
    else if (mask_q[2]) hw = 2'd2;
    else if (mask_q[3]) hw = 2'd3;
    else                hw = 2'd0;
    case (hw)
      2'd0:    imm = value_q[15:0];
      2'd1:    imm = value_q[31:16];
      2'd2:    imm = value_q[47:32];
      default: imm = value_q[63:48];
    endcase
  end

  always_comb begin
    out_instr = 32'd0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_instr = {(first_q ? MOVZ_OPC : MOVK_OPC), hw, imm, rd_q};
      out_last  = last_beat;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      value_q <= 64'd0;
      rd_q    <= 5'd0;
      mask_q  <= 4'd0;
      first_q <= 1'b0;
    end else if (accept) begin
      value_q <= in_value;
      rd_q    <= in_rd;
      mask_q  <= {in_value[63:48] != 16'd0, in_value[47:32] != 16'd0,
                  in_value[31:16] != 16'd0, in_value[15:0]  != 16'd0};
      first_q <= 1'b1;
    end else if (complete) begin
      mask_q  <= rest_mask;
      first_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_materializer.sv
// Bench for imm_materializer: reference beats come from a halfword model and
// are queued at request time, then popped as the block emits each beat.
module tb_imm_materializer;

  localparam logic [8:0] MOVZ = 9'h1A5;
  localparam logic [8:0] MOVK = 9'h1E5;

  logic        CLK = 1'b0;
  logic        Reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [63:0] in_value;
  logic [4:0]  in_rd;
  logic [31:0] out_instr;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [32:0] exp_q[$];

  imm_materializer dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_rd(in_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_last(out_last),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: one beat per nonzero halfword, ascending; a lone MOVZ #0 for zero.
  function automatic void push_model(input logic [63:0] v, input logic [4:0] rd);
    int idx[$];
    for (int k = 0; k < 4; k++)
      if (v[16*k +: 16] != 16'd0) idx.push_back(k);
    if (idx.size() == 0)
      exp_q.push_back({1'b1, MOVZ, 2'd0, 16'd0, rd});
    else
      for (int i = 0; i < idx.size(); i++)
        exp_q.push_back({(i == idx.size() - 1), ((i == 0) ? MOVZ : MOVK),
                         2'(idx[i]), v[16*idx[i] +: 16], rd});
  endfunction

  task automatic send(input logic [63:0] v, input logic [4:0] rd);
    int g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    total_cnt++;
    if (!in_ready) $display("FAIL send_ready: in_ready=%0b required 1 after %0d cycles", in_ready, g);
    else pass_cnt++;
    in_valid = 1'b1; in_value = v; in_rd = rd;
    tick();
    in_valid = 1'b0; in_value = {$urandom, $urandom}; in_rd = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_value = '0; in_rd = '0;
    tick(); tick();
    Reset = 1'b0;
    total_cnt++;
    if ({out_valid, out_last, busy, in_ready, out_instr} !== {4'b0001, 32'd0})
      $display("FAIL reset_state: got v/l/b/r=%b%b%b%b instr=%h required 0001 instr=0",
               out_valid, out_last, busy, in_ready, out_instr);
    else pass_cnt++;
  endtask

  // Fixed vectors with out_ready held high; lit holds the literal words expected.
  task automatic test_vector(input logic [63:0] v, input logic [4:0] rd,
                             input logic [31:0] lit0, input logic [31:0] lit1, input int nb);
    logic [32:0] e;
    int b = 0, g = 0;
    push_model(v, rd);
    send(v, rd);
    out_ready = 1'b1;
    while (exp_q.size() > 0 && g < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({out_last, out_instr} !== e)
          $display("FAIL vec_model: got last=%b instr=%h required last=%b instr=%h", out_last, out_instr, e[32], e[31:0]);
        else pass_cnt++;
        total_cnt++;
        if (out_instr !== ((b == 0) ? lit0 : lit1))
          $display("FAIL vec_literal beat%0d: got %h required %h", b, out_instr, (b == 0) ? lit0 : lit1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL vec_busy: got in_ready=%b busy=%b required 0 1", in_ready, busy);
        else pass_cnt++;
        b++;
      end
      tick(); g++;
    end
    total_cnt++;
    if (b != nb || out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'd0)
      $display("FAIL vec_end: got beats=%0d out_valid=%b in_ready=%b instr=%h required %0d 0 1 0",
               b, out_valid, in_ready, out_instr, nb);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_stall();
    logic [32:0] e;
    push_model(64'h8000_0000_0000_0000, 5'd31);
    out_ready = 1'b0;
    send(64'h8000_0000_0000_0000, 5'd31);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({out_valid, in_ready, out_last, out_instr} !== {3'b101, 32'hD2F0001F})
        $display("FAIL stall_hold cyc%0d: got v=%b r=%b l=%b instr=%h required 1 0 1 d2f0001f",
                 i, out_valid, in_ready, out_last, out_instr);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    total_cnt++;
    if ({out_last, out_instr} !== e)
      $display("FAIL stall_beat: got last=%b instr=%h required last=%b instr=%h", out_last, out_instr, e[32], e[31:0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_end: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    total_cnt++;
    if ({out_last, out_instr} !== {1'b0, 32'hD29FFFE9})
      $display("FAIL rst_first_beat: got last=%b instr=%h required 0 d29fffe9", out_last, out_instr);
    else pass_cnt++;
    tick();
    out_ready = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, busy, out_last, out_instr} !== {4'b0100, 32'd0})
      $display("FAIL rst_abandon: got v=%b r=%b b=%b l=%b instr=%h required 0 1 0 0 0",
               out_valid, in_ready, busy, out_last, out_instr);
    else pass_cnt++;
    out_ready = 1'b1;
    send(64'h5, 5'd7);
    total_cnt++;
    if ({out_last, out_instr} !== {1'b1, 32'hD28000A7})
      $display("FAIL rst_fresh: got last=%b instr=%h required 1 d28000a7", out_last, out_instr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_fresh_end: got out_valid=%b required 0", out_valid);
    else pass_cnt++;
  endtask

  // Random constants, random backpressure; also rebuild each constant from the beats.
  task automatic test_back_to_back();
    logic [63:0] v, recon;
    logic [31:0] held;
    logic        was_stalled;
    logic [32:0] e;
    int g;
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 4; k++)
        v[16*k +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'd0;
      push_model(v, 5'(n + 2));
      out_ready = 1'($urandom_range(0, 1));
      send(v, 5'(n + 2));
      recon = '0; was_stalled = 1'b0; held = '0; g = 0;
      while (exp_q.size() > 0 && g < 100) begin
        if (was_stalled) begin
          total_cnt++;
          if (out_instr !== held) $display("FAIL b2b_stable: got %h required %h", out_instr, held);
          else pass_cnt++;
        end
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          e = exp_q.pop_front();
          total_cnt++;
          if ({out_last, out_instr} !== e)
            $display("FAIL b2b_beat: got last=%b instr=%h required last=%b instr=%h", out_last, out_instr, e[32], e[31:0]);
          else pass_cnt++;
          if (out_instr[31:23] == MOVZ) recon = '0;
          recon[16*out_instr[22:21] +: 16] = out_instr[20:5];
        end
        was_stalled = out_valid && !out_ready;
        held = out_instr;
        tick(); g++;
      end
      total_cnt++;
      if (exp_q.size() != 0 || recon !== v || out_valid !== 1'b0)
        $display("FAIL b2b_decode: got left=%0d recon=%h out_valid=%b required 0 %h 0", exp_q.size(), recon, out_valid, v);
      else pass_cnt++;
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_vector(64'h0000_0000_0000_1234, 5'd3, 32'hD2824683, 32'h0, 1);
    test_vector(64'h0, 5'd0, 32'hD2800000, 32'h0, 1);
    test_vector(64'h0001_0000_0000_FFFF, 5'd1, 32'hD29FFFE1, 32'hF2E00021, 2);
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
